// File: rtl/wallace_mac_accum.sv
// Multiply-accumulate stage around an 8x8 Wallace-tree multiplier.
// Optional WALLACE_MAC_SAT_EN: accumulator saturates instead of wrapping.
module wallace_mul8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [15:0] pp [8];
  logic [15:0] s0, c0, s1, c1, s2, c2;
  logic [15:0] s3, c3, s4, c4, s5, c5;

  function automatic logic [15:0] fa_s(
    input logic [15:0] x, input logic [15:0] y,
    input logic [15:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [15:0] fa_c(
    input logic [15:0] x, input logic [15:0] y,
    input logic [15:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  always_comb begin
    for (int i = 0; i < 8; i++)
      pp[i] = {8'h00, a & {8{b[i]}}} << i;
  end

  // 8 -> 6 -> 4 -> 3 -> 2 carry-save reduction
  always_comb begin
    s0 = fa_s(pp[0], pp[1], pp[2]);
    c0 = fa_c(pp[0], pp[1], pp[2]);
    s1 = fa_s(pp[3], pp[4], pp[5]);
    c1 = fa_c(pp[3], pp[4], pp[5]);
    s2 = fa_s(s0, c0, s1);
    c2 = fa_c(s0, c0, s1);
    s3 = fa_s(c1, pp[6], pp[7]);
    c3 = fa_c(c1, pp[6], pp[7]);
    s4 = fa_s(s2, c2, s3);
    c4 = fa_c(s2, c2, s3);
    s5 = fa_s(s4, c4, c3);
    c5 = fa_c(s4, c4, c3);
    p  = s5 + c5;
  end
endmodule

module wallace_mac_accum #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d;
  logic pend_q, pend_d, plast_q, plast_d;
  logic [15:0] prod_q, prod_d;
  logic pv_q, pv_d, pl_q, pl_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, last_q, last_d;
  logic out_valid_q, out_valid_d;
  logic [15:0] mul_p;
  logic [ACC_W:0] sum_w;
  logic xfer, take, carry;

  wallace_mul8 u_mul (.a(a_q), .b(b_q), .p(mul_p));

  assign in_ready  = !rst && (state_q != DONE) && !last_q;
  assign out_valid = out_valid_q;
  assign out_acc   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

  assign xfer  = in_valid && in_ready;
  assign take  = out_valid_q && out_ready;
  assign sum_w = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, prod_q};
  assign carry = sum_w[ACC_W];

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    plast_d     = plast_q;
    pend_d      = xfer;
    last_d      = last_q;
    prod_d      = mul_p;
    pv_d        = pend_q;
    pl_d        = plast_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    if (xfer) begin
      a_d     = in_a;
      b_d     = in_b;
      plast_d = in_last;
      last_d  = last_q | in_last;
    end

    if (pv_q) begin
`ifdef WALLACE_MAC_SAT_EN
      acc_d = carry ? '1 : sum_w[ACC_W-1:0];
`else
      acc_d = sum_w[ACC_W-1:0];
`endif
      ovf_d = ovf_q | carry;
      if (cnt_q != '1)
        cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (xfer)
          state_d = ACCUM;
      end
      ACCUM: begin
        if (pv_q && pl_q) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (take) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          last_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      pend_q      <= 1'b0;
      plast_q     <= 1'b0;
      last_q      <= 1'b0;
      prod_q      <= '0;
      pv_q        <= 1'b0;
      pl_q        <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      pend_q      <= pend_d;
      plast_q     <= plast_d;
      last_q      <= last_d;
      prod_q      <= prod_d;
      pv_q        <= pv_d;
      pl_q        <= pl_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_wallace_mac_accum.sv
// Randomized bench for wallace_mac_accum against a sum-of-products model.
// Two instances (24/8 and 16/2 widths) share the same stimulus.
module tb_wallace_mac_accum;
  logic clk = 0;
  logic rst, in_valid, in_last, out_ready;
  logic [7:0] in_a, in_b;
  logic in_ready, out_valid, out_ovf;
  logic [23:0] out_acc;
  logic [7:0] out_count;
  logic in_ready1, out_valid1, out_ovf1;
  logic [15:0] out_acc1;
  logic [1:0] out_count1;

  int n_chk = 0;
  int n_err = 0;
  int qa[$];
  int qb[$];

  always #5 clk = ~clk;

  wallace_mac_accum #(.ACC_W(24), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf));

  wallace_mac_accum #(.ACC_W(16), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_acc(out_acc1), .out_count(out_count1), .out_ovf(out_ovf1));

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint exp_acc(input longint sum, input int w);
    longint lim = longint'(1) << w;
`ifdef WALLACE_MAC_SAT_EN
    return (sum >= lim) ? lim - 1 : sum;
`else
    return sum % lim;
`endif
  endfunction

  function automatic longint exp_cnt(input int n, input int cw);
    longint mx = (longint'(1) << cw) - 1;
    return (n > mx) ? mx : longint'(n);
  endfunction

  task automatic add(input int a, input int b);
    qa.push_back(a);
    qb.push_back(b);
  endtask

  task automatic run_pkt(input string tag, input int gap,
                         input int hold);
    longint sum = 0;
    int n = qa.size();
    int i = 0;
    int guard = 0;
    bit hs;
    while (i < n && guard < 4 * n + 20) begin
      @(negedge clk);
      guard++;
      out_ready = 1'($urandom_range(1));
      if (gap > 0 && $urandom_range(99) < gap) begin
        in_valid = 0;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
        in_last = 1'($urandom);
        @(posedge clk);
      end else begin
        in_valid = 1;
        in_a = 8'(qa[i]);
        in_b = 8'(qb[i]);
        in_last = (i == n - 1);
        hs = in_ready;
        chk({tag, ":in_ready"}, in_ready, 1);
        @(posedge clk);
        if (hs) begin
          sum += longint'(qa[i]) * longint'(qb[i]);
          i++;
        end
      end
    end
    chk({tag, ":sent"}, i, n);
    // Junk offered while not ready must be ignored.
    @(negedge clk);
    in_valid = 1;
    in_a = 8'($urandom);
    in_b = 8'($urandom);
    in_last = 1;
    out_ready = 0;
    chk({tag, ":rdy_T"}, in_ready, 0);
    chk({tag, ":ov_T"}, out_valid, 0);
    @(negedge clk);
    chk({tag, ":ov_T1"}, out_valid, 0);
    @(negedge clk);
    chk({tag, ":ov_T2"}, out_valid, 1);
    chk({tag, ":ov1_T2"}, out_valid1, 1);
    chk({tag, ":acc"}, out_acc, exp_acc(sum, 24));
    chk({tag, ":cnt"}, out_count, exp_cnt(n, 8));
    chk({tag, ":ovf"}, out_ovf, sum >= (longint'(1) << 24));
    chk({tag, ":acc1"}, out_acc1, exp_acc(sum, 16));
    chk({tag, ":cnt1"}, out_count1, exp_cnt(n, 2));
    chk({tag, ":ovf1"}, out_ovf1, sum >= (longint'(1) << 16));
    repeat (hold) begin
      @(negedge clk);
      in_a = 8'($urandom);
      chk({tag, ":hold_ov"}, out_valid, 1);
      chk({tag, ":hold_rdy"}, in_ready, 0);
      chk({tag, ":hold_acc"}, out_acc, exp_acc(sum, 24));
      chk({tag, ":hold_cnt"}, out_count, exp_cnt(n, 8));
    end
    out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    out_ready = 0;
    chk({tag, ":take_ov"}, out_valid, 0);
    chk({tag, ":take_rdy"}, in_ready, 1);
    chk({tag, ":take_rdy1"}, in_ready1, 1);
    chk({tag, ":clr_acc"}, out_acc, 0);
    chk({tag, ":clr_cnt"}, out_count, 0);
    chk({tag, ":clr_ovf"}, out_ovf, 0);
    qa.delete();
    qb.delete();
  endtask

  initial begin
    rst = 1;
    in_valid = 0;
    in_last = 0;
    in_a = 0;
    in_b = 0;
    out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", in_ready, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_acc", out_acc, 0);
    chk("rst_cnt", out_count, 0);
    chk("rst_ovf", out_ovf, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_rdy", in_ready, 1);

    add(3, 5); add(10, 20); add(255, 255);
    run_pkt("three", 0, 0);
    add(0, 77);
    run_pkt("zero", 0, 0);
    add(1, 1);
    run_pkt("one", 0, 0);
    add(255, 255); add(255, 255);
    run_pkt("wrap16", 0, 5);
    repeat (5) add(1, 1);
    run_pkt("cntsat", 0, 0);
    repeat (260) add(255, 255);
    run_pkt("long", 0, 0);

    // Reset in the middle of a 4-pair packet.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1;
      in_a = 8'(50 + k);
      in_b = 8'(60 + k);
      in_last = 0;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    chk("mid_rst_rdy", in_ready, 0);
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_acc", out_acc, 0);
    chk("mid_rst_cnt", out_count, 0);
    rst = 0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_flush", out_acc, 0);
    chk("mid_rst_rdy2", in_ready, 1);
    add(2, 3);
    run_pkt("after_rst", 0, 0);

    for (int p = 0; p < 25; p++) begin
      int len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++)
        add($urandom_range(255), $urandom_range(255));
      run_pkt($sformatf("rnd%0d", p), 30, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
